// File: rtl/pcie_tl_fifo_scheduler_if.sv
// FIFO-side bus of the TL scheduler: source FIFO flags/data in,
// pop strobes, output FIFO push/data and current grant out.
interface pcie_tl_fifo_scheduler_if #(
    parameter int DATA_W = 10,
    parameter int N_SRC  = 4
);
    logic [N_SRC-1:0]  src_empty;
    logic [N_SRC-1:0]  src_almost_full;
    logic [DATA_W-1:0] src_data0;
    logic [DATA_W-1:0] src_data1;
    logic [DATA_W-1:0] src_data2;
    logic [DATA_W-1:0] src_data3;
    logic              out_almost_full;
    logic [N_SRC-1:0]  pop;
    logic              push_out;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        grant;

    modport master (
        input  src_empty, src_almost_full,
        input  src_data0, src_data1, src_data2, src_data3,
        input  out_almost_full,
        output pop, push_out, data_out, grant
    );

    modport slave (
        output src_empty, src_almost_full,
        output src_data0, src_data1, src_data2, src_data3,
        output out_almost_full,
        input  pop, push_out, data_out, grant
    );
endinterface

// File: rtl/pcie_tl_fifo_scheduler.sv
// TL FIFO scheduler: one-hot RESET/INIT/IDLE/ACTIVE control FSM,
// threshold registers, and a 4:1 round-robin arbiter with urgency
// override feeding the output FIFO through a 2-stage pop->push pipe.
// Ports: clk, reset_L (async, active low), init, cfg_umbral_sup/inf
// in; state, umbral_superior/inferior, idle out; fifo = source and
// output FIFO bus (pop/push_out/data_out/grant driven here).
module pcie_tl_fifo_scheduler #(
    parameter int DATA_W = 10,
    parameter int UMB_W  = 3,
    parameter int N_SRC  = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic [UMB_W-1:0] cfg_umbral_sup,
    input  logic [UMB_W-1:0] cfg_umbral_inf,
    output logic [3:0]       state,
    output logic [UMB_W-1:0] umbral_superior,
    output logic [UMB_W-1:0] umbral_inferior,
    output logic             idle,
    pcie_tl_fifo_scheduler_if.master fifo
);

    localparam logic [3:0] S_RESET  = 4'b0001;
    localparam logic [3:0] S_INIT   = 4'b0010;
    localparam logic [3:0] S_IDLE   = 4'b0100;
    localparam logic [3:0] S_ACTIVE = 4'b1000;

    logic [3:0]        state_q, state_d;
    logic [UMB_W-1:0]  sup_q, inf_q;
    logic [1:0]        rr_ptr_q;
    logic [N_SRC-1:0]  last_pop_q;
    logic              v1_q;
    logic [1:0]        sel1_q;
    logic              push_q;
    logic [DATA_W-1:0] data_q;

    logic              active;
    logic              load_thr;
    logic [N_SRC-1:0]  elig;
    logic [N_SRC-1:0]  urg;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
    logic [1:0]        rr_j;
    logic [DATA_W-1:0] word;

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; v1_q marks a popped word not yet captured
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   state_d = init ? S_INIT : S_IDLE;
            S_IDLE: begin
                if (init)
                    state_d = S_INIT;
                else if (fifo.src_empty != 4'hF)
                    state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (init)
                    state_d = S_INIT;
                else if (fifo.src_empty == 4'hF && !v1_q)
                    state_d = S_IDLE;
            end
            default:  state_d = S_RESET;
        endcase
    end

    // State-decoded outputs; init blocks new pops in the same cycle
    always_comb begin
        active   = (state_q == S_ACTIVE) && !init;
        load_thr = (state_q == S_INIT);
        idle     = (state_q == S_IDLE);
    end

    // Arbiter: lowest urgent index wins, else first eligible after
    // rr_ptr. Loops run downward so the highest-priority hit lands last.
    always_comb begin
        elig    = '0;
        gnt_idx = 2'd0;
        rr_j    = 2'd0;
        for (int i = 0; i < N_SRC; i++) begin
            elig[i] = active && !fifo.src_empty[i]
                   && !fifo.out_almost_full && !last_pop_q[i];
        end
        urg     = elig & fifo.src_almost_full;
        gnt_vld = |elig;
        if (|urg) begin
            for (int i = N_SRC - 1; i >= 0; i--) begin
                if (urg[i]) gnt_idx = 2'(i);
            end
        end else begin
            for (int k = N_SRC; k >= 1; k--) begin
                rr_j = rr_ptr_q + 2'(k);
                if (elig[rr_j]) gnt_idx = rr_j;
            end
        end
    end

    assign fifo.pop   = gnt_vld ? (N_SRC'(1) << gnt_idx) : '0;
    assign fifo.grant = gnt_vld ? gnt_idx : 2'd0;

    // Word presented by the source popped last cycle
    always_comb begin
        word = fifo.src_data0;
        unique case (sel1_q)
            2'd1:    word = fifo.src_data1;
            2'd2:    word = fifo.src_data2;
            2'd3:    word = fifo.src_data3;
            default: word = fifo.src_data0;
        endcase
    end

    // rr_ptr resets to 3 so source 0 is served first.
    // Zero words are captured but never pushed.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sup_q      <= '0;
            inf_q      <= '0;
            rr_ptr_q   <= 2'd3;
            last_pop_q <= '0;
            v1_q       <= 1'b0;
            sel1_q     <= 2'd0;
            push_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            if (load_thr) begin
                sup_q <= cfg_umbral_sup;
                inf_q <= cfg_umbral_inf;
            end
            if (gnt_vld)
                rr_ptr_q <= gnt_idx;
            last_pop_q <= fifo.pop;
            v1_q       <= gnt_vld;
            sel1_q     <= gnt_idx;
            push_q     <= v1_q && (word != '0);
            if (v1_q)
                data_q <= word;
        end
    end

    assign state           = state_q;
    assign umbral_superior = sup_q;
    assign umbral_inferior = inf_q;
    assign fifo.push_out   = push_q;
    assign fifo.data_out   = data_q;

endmodule

// File: doc/pcie_tl_fifo_scheduler.md
# pcie_tl_fifo_scheduler

Sequencing and arbitration controller for the transaction-layer FIFOs. It drives the shared one-hot `state` bus that resets and configures every FIFO. It also arbitrates four source FIFOs (one per traffic class) onto a single shared output FIFO. Scheduling is round-robin, with an urgency override for sources that are almost full.

## Interface
Parameters:
- `DATA_W`, 10: word width; must match the FIFO.
- `UMB_W`, 3: threshold width.
- `N_SRC`, 4: number of source FIFOs; fixed at 4, index width 2.

Ports:
- `clk`  in  1  — single clock; all logic is on the rising edge.
- `reset_L`  in  1  — asynchronous, active-low reset.
- `init`  in  1  — request (re)configuration.
- `cfg_umbral_sup`  in  3  — almost-full threshold to program.
- `cfg_umbral_inf`  in  3  — almost-empty threshold to program.
- `src_empty`  in  4  — `empty` flag of each source FIFO.
- `src_almost_full`  in  4  — `almost_full` flag of each source FIFO.
- `src_data0`..`src_data3`  in  10 each  — `data_out` of each source FIFO.
- `out_almost_full`  in  1  — `almost_full` flag of the output FIFO.
- `state`  out  4  — one-hot FIFO control state, broadcast to all FIFOs.
- `umbral_superior`, `umbral_inferior`  out  3 each  — registered thresholds, broadcast to all FIFOs.
- `pop`  out  4  — pop strobes to the source FIFOs.
- `push_out`  out  1  — push strobe to the output FIFO.
- `data_out`  out  10  — word written to the output FIFO.
- `grant`  out  2  — index of the source granted in the current cycle.
- `idle`  out  1  — high when `state` is IDLE.

## Operation
- State encoding: RESET = 4'b0001, INIT = 4'b0010, IDLE = 4'b0100, ACTIVE = 4'b1000. `state` is driven directly from the state register.
- State transitions:
  - While `reset_L` = 0: RESET.
  - RESET → INIT on the first edge after `reset_L` rises.
  - INIT: stay while `init` = 1; go to IDLE when `init` = 0.
  - IDLE → ACTIVE when `src_empty` != 4'hF.
  - ACTIVE → IDLE when `src_empty` = 4'hF and no word is in flight.
  - From IDLE or ACTIVE → INIT when `init` = 1. Any in-flight words finish draining; no new pops are issued.
- Thresholds: in INIT, `umbral_superior` and `umbral_inferior` are loaded from the cfg inputs every cycle. In all other states they hold.
- Eligibility: source i is eligible in cycle N only if all of the following hold:
  - `state` = ACTIVE;
  - `src_empty[i]` = 0;
  - `out_almost_full` = 0;
  - i was not granted in cycle N-1. This covers the one-cycle lag of `empty` after a pop.
- Arbitration:
  - If any eligible source has `src_almost_full` = 1, grant the lowest such index (urgent).
  - Otherwise grant the first eligible source in round-robin order, starting from `rr_ptr`+1 mod 4.
  - `rr_ptr` updates to the granted index on every grant, urgent or not.
- Pop: `pop[grant]` = 1 combinationally in the grant cycle. At most one bit of `pop` is high in any cycle. `pop` = 0 when no source is eligible.
- Transfer pipeline:
  - The FIFO presents the popped word during cycle N+1.
  - The block registers that word at the end of N+1.
  - `push_out`/`data_out` are valid in cycle N+2.
- Null words: a word equal to 10'h000 is dropped. `push_out` stays 0 for it, because the FIFO treats zero as null.
- Headroom: up to 2 words are in flight after `out_almost_full` rises. The output FIFO depth minus `umbral_superior` must therefore be ≥ 2.

## Timing
- Reset values (asynchronous): `state` = 0001, thresholds = 0, `pop` = 0, `push_out` = 0, `data_out` = 0, `grant` = 0, `rr_ptr` = 3 (so source 0 is served first), `idle` = 0.
- Latency: pop to push is 2 cycles. Sustained throughput is 1 word/cycle when at least 2 sources are non-empty. A single active source gives 1 word every 2 cycles.
- `reset_L` asserted mid-transfer: the pipeline is discarded immediately and `push_out` = 0 asynchronously. FIFOs reset on the next `clk` edge; the bench must hold `reset_L` low for ≥ 1 edge.
- `init` asserted in ACTIVE: `pop` = 0 from the same cycle. Words already popped still push in the following 2 cycles.

## Test plan
- Reset then `init` pulse:
  - `reset_L` = 0 for 2 clocks → `state` = 0001, all outputs 0.
  - Release → INIT. With `init` = 1 and cfg = 6/2 for 1 cycle → `umbral_superior` = 6, `umbral_inferior` = 2.
  - Then IDLE (0100), `idle` = 1.
- Round-robin:
  - All 4 sources non-empty, none almost full → grant sequence 0,1,2,3,0.
  - `push_out` = 1 from the 3rd cycle after ACTIVE, with data matching each source's word in order.
- Urgent override: sources 1 and 3 non-empty, `src_almost_full[3]` = 1 → grant 3, then 1 (3 is ineligible the next cycle), then 3.
- Backpressure:
  - `out_almost_full` rises in cycle N → `pop` = 0 from N onward, exactly the 2 in-flight pushes complete.
  - When it drops, pops resume next cycle.
- Single source with 1 word: pop in cycle N, no pop in N+1, `push_out` = 1 in N+2, return to IDLE once `src_empty` = F.
- Zero word and reset mid-run:
  - Source word 10'h000 → pop occurs, `push_out` stays 0.
  - `reset_L` dropped mid-stream → `pop`, `push_out` = 0 and `state` = 0001 immediately.
